// File: rtl/oam_dma_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_pkg
// Shared definitions for the OAM DMA engine: sprite attribute memory
// geometry, the DMA trigger register address, echo-RAM folding constants,
// the engine state encoding and the source-page fold helper.
// ---------------------------------------------------------------------------
package oam_dma_pkg;

    localparam logic [15:0] OAM_BASE          = 16'hFE00;
    localparam int          OAM_LEN           = 160;
    localparam logic [15:0] DMA_REG_ADDR      = 16'hFF46;
    localparam logic [7:0]  ECHO_FOLD         = 8'h20;
    localparam logic [7:0]  ECHO_PAGE_MIN_DEF = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } dma_state_e;

    // Pages in the echo region alias work RAM 0x20 pages lower.
    function automatic logic [7:0] fold_page(input logic [7:0] page,
                                             input logic [7:0] echo_min);
        return (page >= echo_min) ? (page - ECHO_FOLD) : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// OAM DMA engine: copies BYTE_COUNT bytes from {page, 00..} to DEST_BASE..
// one byte at a time (read with handshake, then a one-cycle write).
//
// Ports
//   iClock           system clock, rising edge
//   iReset           asynchronous active-low reset
//   iStartWe         one-cycle trigger (CPU write to FF46)
//   iStartPage       source high byte
//   oMcuAddr         bus address (source on read, destination on write)
//   oMcuReadRequest  read request, held until iMcuAck
//   iMcuReadData     read data, sampled on the edge where iMcuAck=1
//   iMcuAck          read acknowledge
//   oMcuWe           one-cycle write strobe
//   oMcuWriteData    write data
//   oBusy            transfer in progress
//   oDone            one-cycle pulse after the final write
// All outputs are registered.
// ---------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int          BYTE_COUNT    = OAM_LEN,
    parameter logic [15:0] DEST_BASE     = OAM_BASE,
    parameter logic [7:0]  ECHO_PAGE_MIN = ECHO_PAGE_MIN_DEF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStartWe,
    input  logic [7:0]  iStartPage,
    output logic [15:0] oMcuAddr,
    output logic        oMcuReadRequest,
    input  logic [7:0]  iMcuReadData,
    input  logic        iMcuAck,
    output logic        oMcuWe,
    output logic [7:0]  oMcuWriteData,
    output logic        oBusy,
    output logic        oDone
);

    localparam logic [7:0] LAST_INDEX = 8'(BYTE_COUNT - 1);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  data_q,  data_d;   // doubles as oMcuWriteData; zero outside WRITE
    logic [15:0] addr_q,  addr_d;
    logic        req_q,   req_d;
    logic        we_q,    we_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic [7:0]  start_page;

    assign start_page = fold_page(iStartPage, ECHO_PAGE_MIN);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        data_d  = 8'h00;
        addr_d  = 16'h0000;
        req_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (iStartWe) begin
            // A trigger in any state restarts: the pending read is dropped,
            // a write already on the bus this cycle completes, and the
            // aborted transfer never reports oDone.
            state_d = ST_READ;
            page_d  = start_page;
            index_d = 8'h00;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            addr_d  = {start_page, 8'h00};
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_READ: begin
                    busy_d = 1'b1;
                    if (iMcuAck) begin
                        state_d = ST_WRITE;
                        data_d  = iMcuReadData;
                        we_d    = 1'b1;
                        addr_d  = DEST_BASE + {8'h00, index_q};
                    end else begin
                        req_d  = 1'b1;
                        addr_d = {page_q, index_q};
                    end
                end
                ST_WRITE: begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        index_d = index_q + 8'h01;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = {page_q, index_q + 8'h01};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
            data_q  <= 8'h00;
            addr_q  <= 16'h0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oMcuAddr        = addr_q;
    assign oMcuReadRequest = req_q;
    assign oMcuWe          = we_q;
    assign oMcuWriteData   = data_q;
    assign oBusy           = busy_q;
    assign oDone           = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Directed bench for oam_dma. A per-cycle task samples the DUT at the falling
// edge, logs bus activity, acts as the source memory (byte = low addr ^ 5A)
// and drives the trigger for the next rising edge.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        iClock;
    logic        iReset;
    logic        iStartWe;
    logic [7:0]  iStartPage;
    logic [15:0] oMcuAddr;
    logic        oMcuReadRequest;
    logic [7:0]  iMcuReadData;
    logic        iMcuAck;
    logic        oMcuWe;
    logic [7:0]  oMcuWriteData;
    logic        oBusy;
    logic        oDone;

    oam_dma dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iStartWe        (iStartWe),
        .iStartPage      (iStartPage),
        .oMcuAddr        (oMcuAddr),
        .oMcuReadRequest (oMcuReadRequest),
        .iMcuReadData    (iMcuReadData),
        .iMcuAck         (iMcuAck),
        .oMcuWe          (oMcuWe),
        .oMcuWriteData   (oMcuWriteData),
        .oBusy           (oBusy),
        .oDone           (oDone)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int n_cmp = 0;
    int n_bad = 0;

    // per-transfer statistics
    int          cyc, busy_cnt, done_cnt, done_at, wr_cnt, stall_hits, first_rd_cyc;
    int          viol_cnt;
    logic        seen_rd;
    logic [15:0] first_rd, last_rd;
    logic [15:0] wr_addr_log [0:199];
    logic [7:0]  wr_data_log [0:199];
    int          wr_cyc_log  [0:199];

    // responder / trigger configuration
    logic [15:0] stall_addr;
    int          stall_left;
    logic        ack_always;
    logic        trig_armed, trig_we, trig_fired;
    logic [15:0] trig_addr;
    logic [7:0]  trig_page;
    int          pre_trig_done;

    task automatic clear_stats();
        cyc          = 0;
        busy_cnt     = 0;
        done_cnt     = 0;
        done_at      = -1;
        wr_cnt       = 0;
        stall_hits   = 0;
        first_rd_cyc = -1;
        seen_rd      = 1'b0;
        first_rd     = 16'h0000;
        last_rd      = 16'h0000;
    endtask

    task automatic clear_config();
        stall_addr    = 16'hFFFF;
        stall_left    = 0;
        ack_always    = 1'b0;
        trig_armed    = 1'b0;
        trig_we       = 1'b0;
        trig_fired    = 1'b0;
        trig_addr     = 16'h0000;
        trig_page     = 8'h00;
        pre_trig_done = 0;
        viol_cnt      = 0;
    endtask

    // One clock: observe at the falling edge (label = cyc), then drive inputs.
    task automatic cycle(input logic start, input logic [7:0] page);
        logic fire;
        @(negedge iClock);
        fire = 1'b0;
        if (oBusy) busy_cnt++;
        if (oDone) begin
            done_cnt++;
            done_at = cyc;
        end
        if (oBusy && oDone) viol_cnt++;
        if (oMcuReadRequest && oMcuWe) viol_cnt++;
        if (oMcuWe) begin
            if (wr_cnt < 200) begin
                wr_addr_log[wr_cnt] = oMcuAddr;
                wr_data_log[wr_cnt] = oMcuWriteData;
                wr_cyc_log[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        if (oMcuReadRequest) begin
            if (!seen_rd) begin
                first_rd     = oMcuAddr;
                first_rd_cyc = cyc;
            end
            seen_rd = 1'b1;
            last_rd = oMcuAddr;
            if (oMcuAddr == stall_addr) stall_hits++;
        end
        if (oMcuReadRequest && oMcuAddr == stall_addr && stall_left > 0) begin
            iMcuAck      = 1'b0;
            iMcuReadData = 8'h00;
            stall_left--;
        end else if (oMcuReadRequest) begin
            iMcuAck      = 1'b1;
            iMcuReadData = oMcuAddr[7:0] ^ 8'h5A;
        end else begin
            iMcuAck      = ack_always;
            iMcuReadData = 8'hFF;
        end
        if (trig_armed && oMcuAddr == trig_addr &&
            ((trig_we && oMcuWe) || (!trig_we && oMcuReadRequest))) begin
            fire          = 1'b1;
            trig_armed    = 1'b0;
            trig_fired    = 1'b1;
            pre_trig_done = done_cnt;
        end
        iStartWe   = start | fire;
        iStartPage = fire ? trig_page : page;
        if (fire) clear_stats();
        cyc++;
    endtask

    task automatic start_xfer(input logic [7:0] page);
        clear_stats();
        cycle(1'b1, page);
    endtask

    // Run until oDone has been seen (bounded), plus a few idle cycles.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL %s timeout: oDone not seen in %0d cycles (required within 1000)", name, n);
        end
        repeat (3) cycle(1'b0, 8'h00);
    endtask

    // Run until a read of addr has been observed (bounded).
    task automatic run_to_read(input string name, input logic [15:0] addr);
        int n;
        n = 0;
        while (!(seen_rd && last_rd == addr) && n < 1000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        n_cmp++;
        if (!(seen_rd && last_rd == addr)) begin
            n_bad++;
            $display("FAIL %s timeout: read of %h not seen (last read %h)", name, addr, last_rd);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_hex(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Writes must be FE00+i carrying i^5A, in order.
    task automatic check_write_seq(input string name);
        int bad_i;
        bad_i = -1;
        for (int i = 0; i < 160; i++) begin
            if (bad_i < 0 && (wr_addr_log[i] !== 16'hFE00 + 16'(i) ||
                              wr_data_log[i] !== (8'(i) ^ 8'h5A)))
                bad_i = i;
        end
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL %s: write %0d got addr %h data %h, expected addr %h data %h",
                     name, bad_i, wr_addr_log[bad_i], wr_data_log[bad_i],
                     16'hFE00 + 16'(bad_i), 8'(bad_i) ^ 8'h5A);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if ({oMcuAddr, oMcuReadRequest, oMcuWe, oMcuWriteData, oBusy, oDone} !== 29'h0) begin
            n_bad++;
            $display("FAIL %s: addr %h req %b we %b wdata %h busy %b done %b, expected all 0",
                     name, oMcuAddr, oMcuReadRequest, oMcuWe, oMcuWriteData, oBusy, oDone);
        end
    endtask

    task automatic test_reset();
        clear_config();
        clear_stats();
        iReset = 1'b0;
        repeat (2) @(negedge iClock);
        check_idle_outputs("reset_outputs");
        iReset = 1'b1;
        repeat (4) cycle(1'b0, 8'h00);
        check_idle_outputs("idle_after_reset");
        cmp_int("idle_no_bus_activity", busy_cnt + wr_cnt + int'(seen_rd), 0);
    endtask

    task automatic test_basic();
        clear_config();
        start_xfer(8'hC1);
        wait_done("basic");
        cmp_hex("basic_first_read", first_rd, 16'hC100);
        cmp_int("basic_first_read_cycle", first_rd_cyc, 1);
        cmp_int("basic_busy_cycles", busy_cnt, 320);
        cmp_int("basic_done_count", done_cnt, 1);
        cmp_int("basic_done_cycle", done_at, 321);
        cmp_int("basic_write_count", wr_cnt, 160);
        check_write_seq("basic_writes");
        cmp_int("basic_protocol", viol_cnt, 0);
        check_idle_outputs("basic_idle_after");
    endtask

    task automatic test_stall();
        clear_config();
        stall_addr = 16'hC105;
        stall_left = 3;
        start_xfer(8'hC1);
        wait_done("stall");
        cmp_int("stall_req_cycles_at_C105", stall_hits, 4);
        cmp_int("stall_byte5_write_cycle", wr_cyc_log[5], 15);
        cmp_int("stall_byte4_write_cycle", wr_cyc_log[4], 10);
        cmp_int("stall_busy_cycles", busy_cnt, 323);
        check_write_seq("stall_writes");
        cmp_int("stall_protocol", viol_cnt, 0);
    endtask

    task automatic test_echo_fold();
        clear_config();
        start_xfer(8'hE3);
        wait_done("echo_e3");
        cmp_hex("echo_e3_first_read", first_rd, 16'hC300);
        cmp_hex("echo_e3_last_read", last_rd, 16'hC39F);
        check_write_seq("echo_e3_writes");
        // Ack held high outside READ must change nothing.
        clear_config();
        ack_always = 1'b1;
        start_xfer(8'hDF);
        wait_done("echo_df");
        cmp_hex("echo_df_first_read", first_rd, 16'hDF00);
        cmp_hex("echo_df_last_read", last_rd, 16'hDF9F);
        cmp_int("echo_df_busy_cycles", busy_cnt, 320);
        cmp_int("echo_df_protocol", viol_cnt, 0);
        check_write_seq("echo_df_writes");
        ack_always = 1'b0;
    endtask

    task automatic test_restart_mid();
        clear_config();
        trig_armed = 1'b1;
        trig_we    = 1'b0;
        trig_addr  = 16'hC132;
        trig_page  = 8'h80;
        start_xfer(8'hC1);
        wait_done("restart_mid");
        cmp_int("restart_mid_fired", int'(trig_fired), 1);
        cmp_int("restart_mid_no_early_done", pre_trig_done, 0);
        cmp_hex("restart_mid_next_read", first_rd, 16'h8000);
        cmp_int("restart_mid_next_read_cycle", first_rd_cyc, 1);
        cmp_hex("restart_mid_next_write", wr_addr_log[0], 16'hFE00);
        cmp_hex("restart_mid_next_wdata", 16'(wr_data_log[0]), 16'h005A);
        cmp_int("restart_mid_done_cycle", done_at, 321);
        cmp_int("restart_mid_done_count", done_cnt, 1);
        check_write_seq("restart_mid_writes");
    endtask

    task automatic test_restart_final();
        clear_config();
        trig_armed = 1'b1;
        trig_we    = 1'b1;
        trig_addr  = 16'hFE9F;
        trig_page  = 8'hD0;
        start_xfer(8'hC1);
        run_to_read("restart_final", 16'hC19F);
        cycle(1'b0, 8'h00);   // observes the final write to FE9F and fires
        cmp_int("restart_final_fe9f_written", int'(trig_fired), 1);
        cycle(1'b0, 8'h00);   // first cycle after the restart
        cmp_int("restart_final_no_done", done_cnt, 0);
        cmp_hex("restart_final_next_read", first_rd, 16'hD000);
        cmp_int("restart_final_next_read_cycle", first_rd_cyc, 1);
        wait_done("restart_final");
        cmp_int("restart_final_new_done_cycle", done_at, 321);
        check_write_seq("restart_final_writes");
    endtask

    task automatic test_async_reset();
        int nz;
        clear_config();
        start_xfer(8'hC1);
        run_to_read("async_reset", 16'hC150);
        #2 iReset = 1'b0;
        #1;
        check_idle_outputs("async_reset_immediate");
        @(posedge iClock);
        @(negedge iClock);
        iReset = 1'b1;
        clear_stats();
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00);
            if ({oMcuAddr, oMcuReadRequest, oMcuWe, oBusy, oDone} !== 20'h0) nz++;
        end
        cmp_int("async_reset_stays_idle", nz, 0);
        cmp_int("async_reset_no_writes", wr_cnt + int'(seen_rd), 0);
        start_xfer(8'hC1);
        wait_done("after_reset");
        cmp_int("after_reset_done_cycle", done_at, 321);
        check_write_seq("after_reset_writes");
    endtask

    initial begin
        iReset       = 1'b0;
        iStartWe     = 1'b0;
        iStartPage   = 8'h00;
        iMcuAck      = 1'b0;
        iMcuReadData = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_echo_fold();
        test_restart_mid();
        test_restart_final();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine. Copies 160 bytes from a CPU-selected source page (XX00–XX9F) into sprite attribute memory (FE00–FE9F).
- Triggered by the MMU when the CPU writes register FF46.
- Acts as the bus-master writer on the memory port. This complements the GPU, which is a read-only master on the same MMU read interface.
- While active it drives oBusy. The MMU uses oBusy to give the DMA bus ownership and to lock the CPU out of OAM.

Parameters:
- BYTE_COUNT, 160, number of bytes transferred per trigger.
- DEST_BASE, 16'hFE00, first destination address.
- ECHO_PAGE_MIN, 8'hE0, source pages at or above this value are folded down by 8'h20 (echo RAM aliasing).

Ports:
- iClock  input  1  system clock; all state changes on the rising edge.
- iReset  input  1  asynchronous, active-low reset.
- iStartWe  input  1  one-cycle strobe: CPU write to FF46 decoded by the MMU.
- iStartPage  input  8  written FF46 value; the source high byte.
- oMcuAddr  output  16  bus address (source during a read, destination during a write).
- oMcuReadRequest  output  1  read request; held high until acknowledged.
- iMcuReadData  input  8  read data, valid when iMcuAck=1.
- iMcuAck  input  1  read acknowledge/grant; data is sampled on this edge.
- oMcuWe  output  1  one-cycle write strobe.
- oMcuWriteData  output  8  write data.
- oBusy  output  1  transfer in progress.
- oDone  output  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (asynchronous, iReset=0):
  - State goes to IDLE; index=0, page=0, data latch=0.
  - All outputs are 0, including oMcuAddr=16'h0000.
  - Takes effect immediately, including mid-transfer. No further bus activity until a new iStartWe.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - All outputs 0.
  - iStartWe=1 latches page (folded: if iStartPage>=ECHO_PAGE_MIN, page=iStartPage-8'h20), sets index=0, goes to READ.
- READ:
  - oBusy=1, oMcuReadRequest=1, oMcuAddr={page,index}.
  - The address is held stable while iMcuAck=0; no timeout.
  - On the edge where iMcuAck=1: latch iMcuReadData, go to WRITE.
  - iMcuAck is ignored in all other states.
- WRITE:
  - Lasts exactly one cycle: oBusy=1, oMcuWe=1, oMcuAddr=DEST_BASE+index, oMcuWriteData=latched byte, oMcuReadRequest=0.
  - Writes are always accepted.
  - If index==BYTE_COUNT-1: go to IDLE and pulse oDone=1 for the following cycle (oBusy=0 in that cycle).
  - Otherwise: index+1, go to READ.
- Index: 8-bit, range 0..BYTE_COUNT-1, never wraps. The source low byte equals index, so source addresses never cross the page.
- Throughput:
  - Minimum 2 cycles per byte when ack comes in the first READ cycle.
  - 320 busy cycles per full transfer.
  - First READ cycle is the cycle after iStartWe.
- Restart: iStartWe in READ or WRITE:
  - Relatch the page, index=0, next state READ.
  - Any pending read is abandoned and its ack is not used.
  - A write occurring in that same cycle still completes.
  - No oDone for the aborted transfer.
  - This also applies when iStartWe coincides with the final WRITE: restart wins and oDone is suppressed.
- oDone and oBusy are never high together.
- oMcuReadRequest and oMcuWe are never high together.

Decomposition:
- Shared definitions header, alongside the existing global definitions:
  - constants for OAM base FE00, OAM length 160, DMA register address FF46, echo fold offset 8'h20;
  - state encodings (localparams) for IDLE/READ/WRITE.
- Single flat module; no sub-module is warranted.
- Index counter and data latch are inline registers.

Test Plan:
- Basic transfer: model memory C100+i = i^8'h5A, iStartWe with page 8'hC1, ack in the first READ cycle.
  -> FE00..FE9F receive 5A..(9F^5A) in order; oBusy high exactly 320 cycles; oDone high for one cycle at cycle 321; then idle.
- Stalled ack: same as above, but ack for byte 5 delayed 3 cycles.
  -> oMcuAddr holds C105 with request high for 4 cycles; no write issued early; byte 5 correct; total busy 323 cycles.
- Echo fold: page 8'hE3.
  -> first read address C300, last C39F; page 8'hDF is not folded (first read DF00).
- Restart mid-transfer: page C1, then iStartWe with page 8'h80 during the READ of byte 50.
  -> next read 8000; next write FE00; no oDone until the new 160-byte transfer completes.
- Restart on the final write: iStartWe coincident with the WRITE to FE9F (page D0).
  -> FE9F is written; oDone stays 0; next cycle reads D000.
- Asynchronous reset mid-transfer: drop iReset during byte 80 READ between clock edges.
  -> oBusy, oMcuReadRequest, oMcuWe and oMcuAddr go to 0 immediately; after release, outputs stay 0 until iStartWe.
